// File: rtl/i2c_reg_sequencer_if.sv
// Bundle of the request/response, I2C-master command/data and status signals around the sequencer.
// The slave modport is the sequencer's view; the master modport is the surrounding host plus i2c_master.
interface i2c_reg_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_read;
  logic [6:0] req_dev_addr;
  logic [7:0] req_reg_addr;
  logic [7:0] req_wdata;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_nack;
  logic       rsp_timeout;

  logic [6:0] m_axis_cmd_address;
  logic       m_axis_cmd_start;
  logic       m_axis_cmd_read;
  logic       m_axis_cmd_write;
  logic       m_axis_cmd_write_multiple;
  logic       m_axis_cmd_stop;
  logic       m_axis_cmd_valid;
  logic       m_axis_cmd_ready;

  logic [7:0] m_axis_data_tdata;
  logic       m_axis_data_tvalid;
  logic       m_axis_data_tlast;
  logic       m_axis_data_tready;

  logic [7:0] s_axis_data_tdata;
  logic       s_axis_data_tvalid;
  logic       s_axis_data_tlast;
  logic       s_axis_data_tready;

  logic       missed_ack;
  logic       busy;

  modport slave (
    input  req_valid, req_read, req_dev_addr, req_reg_addr, req_wdata, rsp_ready,
           m_axis_cmd_ready, m_axis_data_tready,
           s_axis_data_tdata, s_axis_data_tvalid, s_axis_data_tlast, missed_ack, busy,
    output req_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_timeout,
           m_axis_cmd_address, m_axis_cmd_start, m_axis_cmd_read, m_axis_cmd_write,
           m_axis_cmd_write_multiple, m_axis_cmd_stop, m_axis_cmd_valid,
           m_axis_data_tdata, m_axis_data_tvalid, m_axis_data_tlast, s_axis_data_tready
  );

  modport master (
    output req_valid, req_read, req_dev_addr, req_reg_addr, req_wdata, rsp_ready,
           m_axis_cmd_ready, m_axis_data_tready,
           s_axis_data_tdata, s_axis_data_tvalid, s_axis_data_tlast, missed_ack, busy,
    input  req_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_timeout,
           m_axis_cmd_address, m_axis_cmd_start, m_axis_cmd_read, m_axis_cmd_write,
           m_axis_cmd_write_multiple, m_axis_cmd_stop, m_axis_cmd_valid,
           m_axis_data_tdata, m_axis_data_tvalid, m_axis_data_tlast, s_axis_data_tready
  );
endinterface

// File: rtl/i2c_reg_sequencer.sv
// Register-level front end for an AXI-stream I2C master: turns one register read/write
// request into the command/data sequence, guarded by a watchdog, and returns one response.
module i2c_reg_sequencer #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
  input  logic               clk,
  input  logic               rst_n,
  i2c_reg_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, W_CMD, W_REG, W_VAL, W_WAIT, R_CMD_WR, R_REG, R_CMD_RD, R_RX, RESP
  } state_e;

  state_e      state_q, state_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        nack_q, nack_d;
  logic        timeout_q, timeout_d;
  logic        first_q, first_d;
  logic [15:0] wd_q, wd_d;
  logic        armed_q;
  logic        active;
  logic        unused_tlast;

  // The response fields sit still in RESP, so status sampling covers only the bus states.
  assign active       = (state_q != IDLE) && (state_q != RESP);
  assign unused_tlast = bus.s_axis_data_tlast;

  // NOTE: every flop here uses non-blocking assignment so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dev_q     <= '0;
      reg_q     <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      nack_q    <= 1'b0;
      timeout_q <= 1'b0;
      first_q   <= 1'b0;
      wd_q      <= '0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dev_q     <= dev_d;
      reg_q     <= reg_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      nack_q    <= nack_d;
      timeout_q <= timeout_d;
      first_q   <= first_d;
      wd_q      <= wd_d;
      armed_q   <= 1'b1;
    end
  end

  assign bus.m_axis_cmd_address = dev_q;
  assign bus.rsp_rdata          = rdata_q;
  assign bus.rsp_nack           = nack_q;
  assign bus.rsp_timeout        = timeout_q;

  // NOTE: every signal driven below gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    dev_d     = dev_q;
    reg_d     = reg_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    nack_d    = nack_q;
    timeout_d = timeout_q;
    first_d   = 1'b0;
    wd_d      = wd_q;

    bus.req_ready                 = 1'b0;
    bus.rsp_valid                 = 1'b0;
    bus.m_axis_cmd_start          = 1'b0;
    bus.m_axis_cmd_read           = 1'b0;
    bus.m_axis_cmd_write          = 1'b0;
    bus.m_axis_cmd_write_multiple = 1'b0;
    bus.m_axis_cmd_stop           = 1'b0;
    bus.m_axis_cmd_valid          = 1'b0;
    bus.m_axis_data_tdata         = 8'd0;
    bus.m_axis_data_tvalid        = 1'b0;
    bus.m_axis_data_tlast         = 1'b0;
    bus.s_axis_data_tready        = 1'b0;

    if (active && bus.missed_ack) nack_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        // armed_q keeps req_ready low until the first edge after reset release.
        bus.req_ready = armed_q;
        if (armed_q && bus.req_valid) begin
          dev_d     = bus.req_dev_addr;
          reg_d     = bus.req_reg_addr;
          wdata_d   = bus.req_wdata;
          rdata_d   = 8'd0;
          nack_d    = 1'b0;
          timeout_d = 1'b0;
          wd_d      = 16'd0;
          state_d   = bus.req_read ? R_CMD_WR : W_CMD;
        end
      end
      W_CMD: begin
        bus.m_axis_cmd_start          = 1'b1;
        bus.m_axis_cmd_write_multiple = 1'b1;
        bus.m_axis_cmd_stop           = 1'b1;
        bus.m_axis_cmd_valid          = 1'b1;
        if (bus.m_axis_cmd_ready) state_d = W_REG;
      end
      W_REG: begin
        bus.m_axis_data_tdata  = reg_q;
        bus.m_axis_data_tvalid = 1'b1;
        if (bus.m_axis_data_tready) state_d = W_VAL;
      end
      W_VAL: begin
        bus.m_axis_data_tdata  = wdata_q;
        bus.m_axis_data_tlast  = 1'b1;
        bus.m_axis_data_tvalid = 1'b1;
        if (bus.m_axis_data_tready) begin
          state_d = W_WAIT;
          first_d = 1'b1;
        end
      end
      W_WAIT: begin
        // The master raises busy a cycle late, so the entry cycle's busy is not trusted.
        if (!first_q && !bus.busy) state_d = RESP;
      end
      R_CMD_WR: begin
        bus.m_axis_cmd_start = 1'b1;
        bus.m_axis_cmd_write = 1'b1;
        bus.m_axis_cmd_valid = 1'b1;
        if (bus.m_axis_cmd_ready) state_d = R_REG;
      end
      R_REG: begin
        bus.m_axis_data_tdata  = reg_q;
        bus.m_axis_data_tlast  = 1'b1;
        bus.m_axis_data_tvalid = 1'b1;
        if (bus.m_axis_data_tready) state_d = R_CMD_RD;
      end
      R_CMD_RD: begin
        bus.m_axis_cmd_start = 1'b1;
        bus.m_axis_cmd_read  = 1'b1;
        bus.m_axis_cmd_stop  = 1'b1;
        bus.m_axis_cmd_valid = 1'b1;
        if (bus.m_axis_cmd_ready) state_d = R_RX;
      end
      R_RX: begin
        bus.s_axis_data_tready = 1'b1;
        if (bus.s_axis_data_tvalid) begin
          rdata_d = bus.s_axis_data_tdata;
          state_d = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Watchdog overrides whatever the state decided, including a same-cycle completion.
    if (active) begin
      wd_d = wd_q + 16'd1;
      if (wd_d == TIMEOUT_CYCLES) begin
        state_d   = RESP;
        timeout_d = 1'b1;
        rdata_d   = 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Randomized bench for i2c_reg_sequencer: a behavioural I2C target on the master side and
// a register-map reference model predicting responses and the expected command/data stream.
module tb_i2c_reg_sequencer;
  localparam logic [15:0] TO = 16'd100;

  logic clk = 1'b0;
  logic rst_n;
  i2c_reg_sequencer_if bus ();

  i2c_reg_sequencer #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Devices 0x70..0x7F answer; everything else is absent on the bus.
  function automatic bit present(input logic [6:0] d);
    return d[6:4] == 3'b111;
  endfunction

  function automatic logic [15:0] ev_cmd(input logic [6:0] a, input logic s, input logic r,
                                         input logic w, input logic wm, input logic p);
    return {1'b1, 3'b000, a, s, r, w, wm, p};
  endfunction

  function automatic logic [15:0] ev_dat(input logic l, input logic [7:0] d);
    return {1'b0, 6'd0, l, d};
  endfunction

  // ---------------- behavioural I2C target / master-side environment ----------------
  logic [7:0]  tgt_mem [logic [14:0]];
  logic [7:0]  exp_mem [logic [14:0]];
  logic [15:0] obs [$];
  logic [6:0]  cur_dev = '0;
  logic [7:0]  ptr = '0;
  bit          wr_first, wr_stop, ack_pulse, rx_pending, rx_taken, stop_done;
  bit          fast_mode, cmd_stall;
  int          rx_hold = -1;
  int          rx_wait, busy_phase, busy_len;
  int          accept_cyc = 0;

  function automatic logic [7:0] tgt_rd(input logic [14:0] k);
    return tgt_mem.exists(k) ? tgt_mem[k] : 8'h00;
  endfunction

  function automatic logic [7:0] exp_rd(input logic [14:0] k);
    return exp_mem.exists(k) ? exp_mem[k] : 8'h00;
  endfunction

  initial begin
    bus.m_axis_cmd_ready   = 1'b0;
    bus.m_axis_data_tready = 1'b0;
    bus.s_axis_data_tvalid = 1'b0;
    bus.s_axis_data_tdata  = 8'h00;
    bus.s_axis_data_tlast  = 1'b0;
    bus.missed_ack         = 1'b0;
    bus.busy               = 1'b0;
    forever begin
      @(negedge clk);
      bus.missed_ack = ack_pulse;
      ack_pulse = 1'b0;
      // busy rises two cycles after the final write byte, then stays up for busy_len cycles
      case (busy_phase)
        3: busy_phase = 1;
        1: begin bus.busy = 1'b1; busy_phase = 2; end
        2: if (busy_len == 0) begin bus.busy = 1'b0; stop_done = 1'b1; busy_phase = 0; end
           else busy_len--;
        default: ;
      endcase
      if (rx_taken) begin bus.s_axis_data_tvalid = 1'b0; rx_taken = 1'b0; end

      bus.m_axis_cmd_ready   = !cmd_stall && (fast_mode || $urandom_range(0, 1) == 1);
      bus.m_axis_data_tready = fast_mode || $urandom_range(0, 1) == 1;

      if (bus.m_axis_cmd_valid && bus.m_axis_cmd_ready) begin
        obs.push_back(ev_cmd(bus.m_axis_cmd_address, bus.m_axis_cmd_start, bus.m_axis_cmd_read,
                             bus.m_axis_cmd_write, bus.m_axis_cmd_write_multiple, bus.m_axis_cmd_stop));
        cur_dev = bus.m_axis_cmd_address;
        if (!present(cur_dev)) ack_pulse = 1'b1;
        if (bus.m_axis_cmd_read) begin
          rx_pending = 1'b1;
          rx_wait    = $urandom_range(0, 3);
        end else begin
          wr_first = 1'b1;
          wr_stop  = bus.m_axis_cmd_stop;
        end
      end

      if (bus.m_axis_data_tvalid && bus.m_axis_data_tready) begin
        obs.push_back(ev_dat(bus.m_axis_data_tlast, bus.m_axis_data_tdata));
        if (wr_first) begin
          ptr = bus.m_axis_data_tdata;
          wr_first = 1'b0;
        end else if (present(cur_dev)) begin
          tgt_mem[{cur_dev, ptr}] = bus.m_axis_data_tdata;
          ptr++;
        end
        if (bus.m_axis_data_tlast && wr_stop) begin
          busy_phase = 3;
          busy_len   = $urandom_range(1, 4);
        end
      end

      if (rx_pending && !bus.s_axis_data_tvalid) begin
        if ((rx_hold >= 0) ? (cyc - accept_cyc >= rx_hold) : (rx_wait == 0)) begin
          bus.s_axis_data_tvalid = 1'b1;
          bus.s_axis_data_tdata  = present(cur_dev) ? tgt_rd({cur_dev, ptr}) : 8'hFF;
          bus.s_axis_data_tlast  = 1'b1;
        end else if (rx_wait > 0) rx_wait--;
      end
      if (bus.s_axis_data_tvalid && bus.s_axis_data_tready) begin
        rx_taken   = 1'b1;
        rx_pending = 1'b0;
      end
    end
  end

  // ---------------- requester side ----------------
  function automatic logic [63:0] dut_outs();
    return {28'd0, bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_nack, bus.rsp_timeout,
            bus.m_axis_cmd_address, bus.m_axis_cmd_start, bus.m_axis_cmd_read, bus.m_axis_cmd_write,
            bus.m_axis_cmd_write_multiple, bus.m_axis_cmd_stop, bus.m_axis_cmd_valid,
            bus.m_axis_data_tdata, bus.m_axis_data_tvalid, bus.m_axis_data_tlast,
            bus.s_axis_data_tready};
  endfunction

  task automatic send_req(input bit rd, input logic [6:0] dev, input logic [7:0] ra,
                          input logic [7:0] wd);
    int n;
    @(negedge clk);
    bus.req_read     = rd;
    bus.req_dev_addr = dev;
    bus.req_reg_addr = ra;
    bus.req_wdata    = wd;
    bus.req_valid    = 1'b1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("req_accept", bus.req_ready, 1'b1);
    accept_cyc = cyc + 1;
    obs.delete();
    stop_done = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic do_txn(input bit rd, input logic [6:0] dev, input logic [7:0] ra,
                        input logic [7:0] wd, input bit exp_to, input int hold, input int exp_lat);
    logic [7:0]  e_rdata;
    logic        e_nack;
    logic [15:0] eq [$];
    int          n;
    bit          stable;
    e_nack  = !exp_to && !present(dev);
    e_rdata = (exp_to || !rd) ? 8'h00 : (present(dev) ? exp_rd({dev, ra}) : 8'hFF);
    if (!exp_to && !rd && present(dev)) exp_mem[{dev, ra}] = wd;
    if (rd) begin
      eq.push_back(ev_cmd(dev, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
      eq.push_back(ev_dat(1'b1, ra));
      eq.push_back(ev_cmd(dev, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
    end else begin
      eq.push_back(ev_cmd(dev, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
      eq.push_back(ev_dat(1'b0, ra));
      eq.push_back(ev_dat(1'b1, wd));
    end

    send_req(rd, dev, ra, wd);
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    check("rsp_seen", bus.rsp_valid, 1'b1);
    if (exp_lat >= 0) check("timeout_latency", cyc - accept_cyc, exp_lat);
    check("rsp_rdata", bus.rsp_rdata, e_rdata);
    check("rsp_nack", bus.rsp_nack, e_nack);
    check("rsp_timeout", bus.rsp_timeout, exp_to);
    if (!exp_to) begin
      check("bus_len", obs.size(), eq.size());
      for (int i = 0; i < eq.size() && i < obs.size(); i++) check("bus_event", obs[i], eq[i]);
      if (!rd) check("stop_done", stop_done, 1'b1);
    end

    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== e_rdata || bus.rsp_nack !== e_nack ||
          bus.rsp_timeout !== exp_to || bus.req_ready !== 1'b0) stable = 1'b0;
    end
    if (hold > 0) check("rsp_hold_stable", stable, 1'b1);

    bus.rsp_ready = 1'b1;
    check("no_ready_in_rsp", bus.req_ready, 1'b0);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("rsp_drop", bus.rsp_valid, 1'b0);
    check("ready_back", bus.req_ready, 1'b1);
  endtask

  logic [6:0] devs [5] = '{7'h70, 7'h71, 7'h7F, 7'h01, 7'h33};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bus.req_valid    = 1'b0;
    bus.req_read     = 1'b0;
    bus.req_dev_addr = '0;
    bus.req_reg_addr = '0;
    bus.req_wdata    = '0;
    bus.rsp_ready    = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", dut_outs(), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", bus.req_ready, 1'b1);

    // directed: write, preloaded read with repeated start, absent device
    do_txn(1'b0, 7'h70, 8'h00, 8'h37, 1'b0, 0, -1);
    check("target_data", tgt_rd({7'h70, 8'h00}), 8'h37);
    tgt_mem[{7'h70, 8'h00}] = 8'h7B;
    exp_mem[{7'h70, 8'h00}] = 8'h7B;
    do_txn(1'b1, 7'h70, 8'h00, 8'h00, 1'b0, 0, -1);
    do_txn(1'b0, 7'h01, 8'h05, 8'hA5, 1'b0, 0, -1);
    do_txn(1'b1, 7'h71, 8'h03, 8'h00, 1'b0, 50, -1);

    for (int t = 0; t < 40; t++)
      do_txn(1'($urandom_range(0, 1)), devs[$urandom_range(0, 4)], 8'($urandom_range(0, 7)),
             8'($urandom), 1'b0, $urandom_range(0, 3), -1);

    // command channel stalled: watchdog must fire exactly TO cycles after accept
    cmd_stall = 1'b1;
    do_txn(1'b0, 7'h70, 8'h02, 8'h11, 1'b1, 0, 100);
    cmd_stall = 1'b0;

    // read byte arrives one cycle before, then exactly on, the watchdog limit
    fast_mode = 1'b1;
    rx_hold   = 98;
    do_txn(1'b1, 7'h70, 8'h00, 8'h00, 1'b0, 0, -1);
    rx_hold   = 99;
    do_txn(1'b1, 7'h70, 8'h00, 8'h00, 1'b1, 0, -1);
    fast_mode = 1'b0;

    // reset asserted while waiting for read data
    rx_hold = 100000;
    send_req(1'b1, 7'h70, 8'h01, 8'h00);
    n = 0;
    while (bus.s_axis_data_tready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("reached_rx", bus.s_axis_data_tready, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", dut_outs(), 64'd0);
    rx_pending = 1'b0;
    rx_hold    = -1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_midreset", bus.req_ready, 1'b1);
    check("no_rsp_after_midreset", bus.rsp_valid, 1'b0);

    do_txn(1'b1, 7'h70, 8'h00, 8'h00, 1'b0, 1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
